instr_mem_responder: RTL
========================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 The block SHALL have one clock and one reset: clk, single clock, all state on rising edge; rst_n, reset, asynchronous assert, active-low.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid_i  in  1  fetch presents PC
- req_addr_i  in  8  PC to read
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i
- flush_i  in  1  jump/start taken; discard in-flight and queued responses
- load_en_i  in  1  program-load write strobe
- load_addr_i  in  8  write address
- load_data_i  in  9  instruction word to write
- rsp_valid_o  out  1  response available
- rsp_addr_o  out  8  PC of the presented response
- rsp_instr_o  out  9  instruction at rsp_addr_o
- rsp_ready_i  in  1  consumer takes response when high with rsp_valid_o
- halt_o  out  1  halt instruction detected (see Configuration)

Function
REQ-003 Storage SHALL be 256 x 9-bit words with synchronous read, fully addressed by 8 bits (no wrap logic needed).
REQ-004 Accepted request at cycle N SHALL read memory in cycle N and push {addr, instr} into a 2-entry output FIFO at edge N+1; minimum request-to-rsp_valid_o latency 1 cycle.
REQ-005 Occupancy = FIFO count (0..2) + in-flight read (0..1); req_ready_o SHALL equal (occupancy < 2) AND NOT load_en_i; occupancy SHALL never exceed 2.
REQ-006 Responses SHALL be delivered in request order; rsp_valid_o = (count != 0); rsp_addr_o/rsp_instr_o SHALL show the FIFO head and stay stable while rsp_valid_o high and rsp_ready_i low.
REQ-007 Push and pop in the same cycle SHALL leave count unchanged; pop from empty and push to full SHALL never occur.
REQ-008 load_en_i SHALL write load_data_i to load_addr_i at the rising edge; no request is accepted that cycle, so no read/write collision exists.
REQ-009 flush_i SHALL, at the next edge, empty the FIFO and cancel the in-flight read (cancelled read not pushed); rsp_valid_o SHALL be low the cycle after flush.
REQ-010 A request presented with flush_i high SHALL be judged with occupancy taken as 0 (req_ready_o high unless load_en_i) and its response SHALL be the first delivered after flush.
REQ-011 flush_i and rsp_ready_i high together: flush wins; the head is considered not consumed.

Reset
REQ-012 On rst_n low, asynchronously: FIFO count 0, in-flight cleared, rsp_valid_o 0, rsp_addr_o 0, rsp_instr_o 0, halt_o 0; req_ready_o SHALL be 1 (when load_en_i low) during and after reset.
REQ-013 Memory contents SHALL NOT be cleared by reset; reset mid-operation SHALL drop all queued/in-flight responses.

Configuration
REQ-014 Macro INSTR_MEM_HALT_DETECT_EN: when defined, halt_o SHALL set at the edge a response with rsp_instr_o == 9'h1FF is popped, stay set (sticky) until rst_n low or flush_i high, and while set req_ready_o SHALL be 0.
REQ-015 Without INSTR_MEM_HALT_DETECT_EN, halt_o SHALL be tied 0 and no detection logic SHALL be present.

Verification
REQ-016 The bench SHALL cover:
- Load 0x05=9'h0A3, 0x06=9'h111; request 0x05 then 0x06, rsp_ready_i=1 -> rsp (0x05,0A3) at N+1, (0x06,111) at N+2.
- rsp_ready_i=0, request 0x05,0x06,0x07 back-to-back -> req_ready_o low on third; head (0x05,0A3) held stable; after pop 0x07 accepted.
- Request 0x05, flush_i with request 0x40 next cycle -> 0x05 never delivered; first response addr 0x40.
- load_en_i high with req_valid_i high -> req_ready_o 0, write lands, following read returns new word.
- rst_n low with 2 queued -> rsp_valid_o 0 immediately; read of prior-loaded address after reset returns loaded data.
- With INSTR_MEM_HALT_DETECT_EN, pop word 9'h1FF -> halt_o 1 next edge, req_ready_o 0; flush_i clears; without macro halt_o stays 0.

Source files
------------

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: 256 x 9-bit instruction memory serving fetch requests
// through a two-entry in-order response FIFO.
//
// Optional feature macro: INSTR_MEM_HALT_DETECT_EN
//   When defined, popping an instruction equal to 9'h1FF sets a sticky halt_o.
//   While halt_o is set, new requests are refused. Reset or flush_i clears it.
//   When undefined, halt_o is tied low and no detection logic is built.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The request side (req_ready_o) is combinational on load_en_i and flush_i
//   and is independent of req_valid_i. The response side presents the FIFO head
//   and holds it stable until the head is popped.
//
// Pipeline notes:
//   - A request accepted in cycle N reads memory. The word is captured straight
//     into a FIFO slot at edge N+1, so rsp_valid_o can rise one cycle after
//     acceptance.
//   - A request accepted in the same cycle as flush_i is parked in an in-flight
//     register for one cycle. It is pushed at the following edge. This keeps
//     rsp_valid_o low for the cycle after a flush, while that request is still
//     the first response delivered after the flush.
//   - Occupancy is the FIFO count plus the in-flight bit. New requests are only
//     accepted while occupancy < 2, so two pushes in one edge always fit.
module instr_mem_responder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_i,
  input  logic [7:0] req_addr_i,
  output logic       req_ready_o,
  input  logic       flush_i,
  input  logic       load_en_i,
  input  logic [7:0] load_addr_i,
  input  logic [8:0] load_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_addr_o,
  output logic [8:0] rsp_instr_o,
  input  logic       rsp_ready_i,
  output logic       halt_o
);

  localparam int AW    = 8;
  localparam int DW    = 9;
  localparam int DEPTH = 256;
  localparam logic [DW-1:0] HALT_WORD = 9'h1FF;

  // Instruction storage. It is deliberately not reset, so reset keeps the program.
  logic [DW-1:0] mem_q [DEPTH];

  // FIFO: slot 0 is always the head, and slot 1 is the entry behind it.
  logic [1:0]    count_q, count_d;
  logic [AW-1:0] addr0_q, addr0_d;
  logic [AW-1:0] addr1_q, addr1_d;
  logic [DW-1:0] instr0_q, instr0_d;
  logic [DW-1:0] instr1_q, instr1_d;

  // In-flight register. It holds a request accepted alongside a flush.
  logic          inflight_q, inflight_d;
  logic [AW-1:0] infl_addr_q, infl_addr_d;
  logic [DW-1:0] infl_instr_q, infl_instr_d;

  logic          halt_q;
  logic [1:0]    occupancy;
  logic          accept;
  logic          pop;
  logic [DW-1:0] rd_word;

  // Memory word addressed by the current request. It is captured at the next edge.
  always_comb begin
    rd_word = mem_q[req_addr_i];
  end

  // Program-load write port. No request is accepted while it is active.
  always_ff @(posedge clk) begin
    if (load_en_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  // Occupancy and request acceptance.
  // A flush empties everything, so acceptance ignores occupancy during a flush.
  always_comb begin
    occupancy   = count_q + {1'b0, inflight_q};
    req_ready_o = 1'b0;
    if (!load_en_i && !halt_q) begin
      req_ready_o = flush_i || (occupancy < 2'd2);
    end
    accept = req_valid_i && req_ready_o;
    // A flush wins over a simultaneous consume. The head is not counted as taken.
    pop    = (count_q != 2'd0) && rsp_ready_i && !flush_i;
  end

  // Next state for the FIFO and the in-flight register.
  // Order of operations: pop the head, then append the in-flight entry, then
  // append the newly accepted request.
  always_comb begin
    count_d      = count_q;
    addr0_d      = addr0_q;
    addr1_d      = addr1_q;
    instr0_d     = instr0_q;
    instr1_d     = instr1_q;
    inflight_d   = 1'b0;
    infl_addr_d  = infl_addr_q;
    infl_instr_d = infl_instr_q;

    if (flush_i) begin
      // Drop queued responses and any in-flight read.
      // Only a request accepted this cycle survives, parked as in-flight.
      count_d = 2'd0;
      if (accept) begin
        inflight_d   = 1'b1;
        infl_addr_d  = req_addr_i;
        infl_instr_d = rd_word;
      end
    end else begin
      if (pop) begin
        addr0_d  = addr1_q;
        instr0_d = instr1_q;
        count_d  = count_d - 2'd1;
      end
      if (inflight_q) begin
        if (count_d == 2'd0) begin
          addr0_d  = infl_addr_q;
          instr0_d = infl_instr_q;
        end else begin
          addr1_d  = infl_addr_q;
          instr1_d = infl_instr_q;
        end
        count_d = count_d + 2'd1;
      end
      if (accept) begin
        if (count_d == 2'd0) begin
          addr0_d  = req_addr_i;
          instr0_d = rd_word;
        end else begin
          addr1_d  = req_addr_i;
          instr1_d = rd_word;
        end
        count_d = count_d + 2'd1;
      end
    end
  end

  // FIFO and in-flight state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      addr0_q      <= '0;
      addr1_q      <= '0;
      instr0_q     <= '0;
      instr1_q     <= '0;
      inflight_q   <= 1'b0;
      infl_addr_q  <= '0;
      infl_instr_q <= '0;
    end else begin
      count_q      <= count_d;
      addr0_q      <= addr0_d;
      addr1_q      <= addr1_d;
      instr0_q     <= instr0_d;
      instr1_q     <= instr1_d;
      inflight_q   <= inflight_d;
      infl_addr_q  <= infl_addr_d;
      infl_instr_q <= infl_instr_d;
    end
  end

`ifdef INSTR_MEM_HALT_DETECT_EN
  logic halt_d;

  // Sticky halt. It is set when the halt word leaves the FIFO and cleared by flush.
  always_comb begin
    halt_d = halt_q;
    if (flush_i) begin
      halt_d = 1'b0;
    end else if (pop && (instr0_q == HALT_WORD)) begin
      halt_d = 1'b1;
    end
  end

  // Halt flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end
`else
  // Halt detection is absent, so the flag is constant low.
  assign halt_q = 1'b0;
`endif

  // Response outputs always show the FIFO head.
  assign rsp_valid_o = (count_q != 2'd0);
  assign rsp_addr_o  = addr0_q;
  assign rsp_instr_o = instr0_q;
  assign halt_o      = halt_q;

endmodule
